fetch_seq: RTL and testbench
============================

# fetch_seq

Instruction fetch sequencer that drives the 16-bit program counter. It reads the current PC, fetches one 16-bit instruction word over a request/acknowledge memory handshake, and latches it into an instruction register. It then decodes the opcode and issues exactly one PC update strobe (`inc`, `add` or `sub`, with `offset`) back to the PC block. It also counts retired instructions and stops on a halt instruction.

## Interface

Parameters: none (all widths fixed at 16).

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  enables fetching; sampled in IDLE and at the end of each EXEC
- `pc`  in  16  current program counter from the PC block
- `mem_ack`  in  1  memory has `mem_rdata` valid this cycle
- `mem_rdata`  in  16  instruction word from memory
- `mem_req`  out  1  fetch request, held until acknowledged
- `mem_addr`  out  16  fetch address; equals `pc` while `mem_req`=1, else 0
- `inc`  out  1  PC strobe: pc ← pc+1
- `add`  out  1  PC strobe: pc ← pc+offset
- `sub`  out  1  PC strobe: pc ← pc−offset
- `offset`  out  16  branch distance; zero-extended `ir[13:0]` during add/sub, else 0
- `ir`  out  16  last fetched instruction
- `ir_valid`  out  1  one-cycle pulse: `ir` holds a newly fetched instruction
- `halted`  out  1  a halt instruction has been executed
- `icount`  out  16  retired-instruction counter

## Operation

- States: IDLE, FETCH, EXEC, HALT. State is held in a register, and all outputs are decoded from state plus `ir`/`pc` (Moore).
- IDLE: all strobes 0, `mem_req`=0. When `run`=1, go to FETCH; otherwise stay.
- FETCH: `mem_req`=1, `mem_addr`=`pc`. On an edge with `mem_ack`=1: `ir` ← `mem_rdata`, go to EXEC. With `mem_ack`=0, stay in FETCH, holding `mem_req` and `mem_addr` stable.
- EXEC: `ir_valid`=1. Decode `ir[15:14]`:
  - 00 → `inc`=1
  - 01 → `add`=1, `offset`={2'b00, ir[13:0]}
  - 10 → `sub`=1, `offset`={2'b00, ir[13:0]}
  - 11 → halt: no strobe, next state HALT
- For non-halt opcodes, the next state is FETCH if `run`=1, else IDLE.
- `icount` increments by 1 on every EXEC edge, including halt. It wraps from 0xFFFF to 0x0000.
- HALT: `halted`=1, all strobes 0, `mem_req`=0. Exit only via reset; `run` is ignored.
- Strobes are mutually exclusive and never high outside EXEC.
- Branch targets are relative to the branch instruction's own address. `pc` is unchanged until the EXEC edge.
- PC arithmetic is modulo 2^16 and is performed by the PC block. Offset 0 (branch-to-self) is legal.
- `mem_ack` is ignored in every state except FETCH. `mem_rdata` is sampled only on the acknowledging edge.

## Timing

- Reset (`reset`=0) takes effect immediately, regardless of clock. It forces:
  - state=IDLE
  - `ir`=0x0000, `icount`=0x0000, `halted`=0
  - `mem_req`=0, `mem_addr`=0
  - `inc`=`add`=`sub`=0, `offset`=0, `ir_valid`=0
- Reset asserted mid-FETCH drops `mem_req` in the same cycle. Any acknowledge that arrives while in reset is discarded.
- First `mem_req` appears one cycle after the edge that samples `run`=1 in IDLE.
- `mem_ack` may arrive in the first FETCH cycle. Zero-wait memory gives 2 cycles per instruction (FETCH, EXEC). Each wait cycle adds 1.
- The PC block updates on the EXEC edge. The next FETCH cycle presents the new `pc` on `mem_addr`.
- `ir_valid` and the strobe are high for exactly one cycle per instruction.
- `run` dropped during FETCH does not abort the fetch. The instruction completes, then the block enters IDLE.

## Test plan

- Reset, `run`=1, zero-wait memory returning 0x0000 → `mem_addr` 0x0000, 0x0001, 0x0002 on successive FETCH cycles. `inc` pulses every 2nd cycle, and `icount`=3 after three EXECs.
- `pc`=0x0010, fetch 0x4005 → in EXEC, `add`=1 and `offset`=0x0005. The next FETCH `mem_addr`=0x0015.
- `pc`=0x0003, fetch 0x8005 → `sub`=1 and `offset`=0x0005. The next `mem_addr`=0xFFFE (wrap).
- `mem_ack` delayed 3 cycles → `mem_req`=1 and `mem_addr` stable for 4 cycles. No strobe and no `ir_valid` until the acknowledging edge.
- Fetch 0xC000 → `ir_valid` pulses and no strobe fires. `halted`=1 from the next cycle, `mem_req` stays 0 with `run`=1, and `icount` has incremented.
- Assert `reset` mid-FETCH with `mem_ack` high → outputs clear immediately and `ir` stays 0x0000. After release with `run`=1, fetching restarts at IDLE→FETCH.

Source files
------------

// File: rtl/fetch_seq_if.sv
//------------------------------------------------------------------------------
// fetch_seq_if : run/PC/memory/strobe bundle between the fetch sequencer and
//                its environment (PC block, instruction memory). Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_seq_if;
  logic        run;
  logic [15:0] pc;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        inc;
  logic        add;
  logic        sub;
  logic [15:0] offset;
  logic [15:0] ir;
  logic        ir_valid;
  logic        halted;
  logic [15:0] icount;

  modport master (
    input  run, pc, mem_ack, mem_rdata,
    output mem_req, mem_addr, inc, add, sub, offset, ir, ir_valid, halted, icount
  );

  modport slave (
    output run, pc, mem_ack, mem_rdata,
    input  mem_req, mem_addr, inc, add, sub, offset, ir, ir_valid, halted, icount
  );
endinterface

`default_nettype wire

// File: rtl/fetch_seq.sv
//------------------------------------------------------------------------------
// fetch_seq : instruction fetch sequencer issuing one PC update strobe per
//             fetched instruction, with retired count and halt. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_seq (
  input  wire logic     clk,
  input  wire logic     reset,
  fetch_seq_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] c_OP_INC  = 2'b00;
  localparam logic [1:0] c_OP_ADD  = 2'b01;
  localparam logic [1:0] c_OP_SUB  = 2'b10;
  localparam logic [1:0] c_OP_HALT = 2'b11;

  state_t      state_q;
  logic [15:0] ir_q;
  logic [15:0] icount_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ir_q     <= 16'h0000;
      icount_q <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            ir_q    <= bus.mem_rdata;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          icount_q <= icount_q + 16'd1;
          if (ir_q[15:14] == c_OP_HALT) state_q <= S_HALT;
          else if (bus.run)             state_q <= S_FETCH;
          else                          state_q <= S_IDLE;
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Outputs are pure decodes of the state register, so an asserted reset
  // clears them without waiting for a clock edge.
  logic w_fetch;
  logic w_exec;
  logic w_branch;

  assign w_fetch  = (state_q == S_FETCH);
  assign w_exec   = (state_q == S_EXEC);
  assign w_branch = bus.add | bus.sub;

  assign bus.mem_req  = w_fetch;
  assign bus.mem_addr = w_fetch ? bus.pc : 16'h0000;
  assign bus.inc      = w_exec && (ir_q[15:14] == c_OP_INC);
  assign bus.add      = w_exec && (ir_q[15:14] == c_OP_ADD);
  assign bus.sub      = w_exec && (ir_q[15:14] == c_OP_SUB);
  assign bus.offset   = w_branch ? {2'b00, ir_q[13:0]} : 16'h0000;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = w_exec;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.icount   = icount_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
//------------------------------------------------------------------------------
// tb_fetch_seq : directed bench for fetch_seq with a behavioural PC block and
//                hand-driven memory responses. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  logic        pc_force;
  logic [15:0] pc_force_val;
  logic [15:0] pc_q;

  fetch_seq_if bus();

  fetch_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC block: applies strobes on the EXEC edge; pc_force preloads a start address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc_q <= 16'h0000;
    else if (pc_force) pc_q <= pc_force_val;
    else if (bus.inc)  pc_q <= pc_q + 16'd1;
    else if (bus.add)  pc_q <= pc_q + bus.offset;
    else if (bus.sub)  pc_q <= pc_q - bus.offset;
  end
  assign bus.pc = pc_q;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_req"},    {15'd0, bus.mem_req},  16'h0000);
    chk({tag, "_addr"},   bus.mem_addr,          16'h0000);
    chk({tag, "_strobe"}, {13'd0, bus.inc, bus.add, bus.sub}, 16'h0000);
    chk({tag, "_irv"},    {15'd0, bus.ir_valid}, 16'h0000);
    chk({tag, "_off"},    bus.offset,            16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset = 1'b0;
    bus.run = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    pc_force = 1'b0;
    pc_force_val = 16'h0000;

    #1;
    chk_idle_outs("rst");
    chk("rst_ir",     bus.ir,              16'h0000);
    chk("rst_icount", bus.icount,          16'h0000);
    chk("rst_halted", {15'd0, bus.halted}, 16'h0000);

    // Sequential zero-wait fetches of 0x0000
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("seq_f0_req",  {15'd0, bus.mem_req}, 16'h0001);
    chk("seq_f0_addr", bus.mem_addr,         16'h0000);
    chk("seq_f0_inc",  {15'd0, bus.inc},     16'h0000);
    @(negedge clk);
    chk("seq_e0_inc",  {15'd0, bus.inc},      16'h0001);
    chk("seq_e0_irv",  {15'd0, bus.ir_valid}, 16'h0001);
    chk("seq_e0_req",  {15'd0, bus.mem_req},  16'h0000);
    @(negedge clk);
    chk("seq_f1_addr", bus.mem_addr,     16'h0001);
    chk("seq_f1_inc",  {15'd0, bus.inc}, 16'h0000);
    @(negedge clk);
    chk("seq_e1_inc",  {15'd0, bus.inc}, 16'h0001);
    @(negedge clk);
    chk("seq_f2_addr", bus.mem_addr, 16'h0002);
    @(negedge clk);
    chk("seq_e2_inc",  {15'd0, bus.inc}, 16'h0001);
    bus.run = 1'b0;
    @(negedge clk);
    chk("seq_icount",  bus.icount,           16'h0003);
    chk("seq_idle_req", {15'd0, bus.mem_req}, 16'h0000);

    // Forward branch from 0x0010
    pc_force = 1'b1;
    pc_force_val = 16'h0010;
    bus.mem_rdata = 16'h4005;
    bus.run = 1'b1;
    @(negedge clk);
    pc_force = 1'b0;
    chk("add_f_addr", bus.mem_addr, 16'h0010);
    @(negedge clk);
    chk("add_e_add",  {15'd0, bus.add}, 16'h0001);
    chk("add_e_inc",  {15'd0, bus.inc}, 16'h0000);
    chk("add_e_off",  bus.offset,       16'h0005);
    chk("add_e_ir",   bus.ir,           16'h4005);
    bus.mem_ack = 1'b0;

    // Three wait cycles: request held stable for four FETCH cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_req",  {15'd0, bus.mem_req},  16'h0001);
      chk("wait_addr", bus.mem_addr,          16'h0015);
      chk("wait_irv",  {15'd0, bus.ir_valid}, 16'h0000);
      chk("wait_strb", {13'd0, bus.inc, bus.add, bus.sub}, 16'h0000);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h0000;
    bus.run = 1'b0;
    @(negedge clk);
    chk("wait_e_inc", {15'd0, bus.inc},      16'h0001);
    chk("wait_e_irv", {15'd0, bus.ir_valid}, 16'h0001);
    @(negedge clk);
    chk("wait_icount", bus.icount,          16'h0005);
    chk("wait_idle",   {15'd0, bus.mem_req}, 16'h0000);

    // Backward branch from 0x0003 wraps below zero; run dropped mid-fetch
    pc_force = 1'b1;
    pc_force_val = 16'h0003;
    bus.mem_rdata = 16'h8005;
    bus.run = 1'b1;
    @(negedge clk);
    pc_force = 1'b0;
    chk("sub_f_addr", bus.mem_addr, 16'h0003);
    bus.run = 1'b0;
    @(negedge clk);
    chk("sub_e_sub", {15'd0, bus.sub}, 16'h0001);
    chk("sub_e_add", {15'd0, bus.add}, 16'h0000);
    chk("sub_e_off", bus.offset,       16'h0005);
    @(negedge clk);
    chk("sub_idle_req", {15'd0, bus.mem_req}, 16'h0000);
    bus.run = 1'b1;
    bus.mem_rdata = 16'hC000;
    @(negedge clk);
    chk("wrap_addr", bus.mem_addr, 16'hFFFE);

    // Halt
    @(negedge clk);
    chk("halt_e_irv",   {15'd0, bus.ir_valid}, 16'h0001);
    chk("halt_e_strb",  {13'd0, bus.inc, bus.add, bus.sub}, 16'h0000);
    chk("halt_e_off",   bus.offset,            16'h0000);
    chk("halt_e_hlt",   {15'd0, bus.halted},   16'h0000);
    @(negedge clk);
    chk("halt_hlt",     {15'd0, bus.halted},   16'h0001);
    chk("halt_icount",  bus.icount,            16'h0007);
    chk_idle_outs("halt1");
    @(negedge clk);
    chk("halt2_hlt",    {15'd0, bus.halted},   16'h0001);
    chk_idle_outs("halt2");

    // Reset clears halt
    reset = 1'b0;
    #1;
    chk("rst2_hlt",    {15'd0, bus.halted}, 16'h0000);
    chk("rst2_icount", bus.icount,          16'h0000);
    chk("rst2_ir",     bus.ir,              16'h0000);

    // Reset asserted mid-FETCH with an acknowledge pending
    @(negedge clk);
    reset = 1'b1;
    bus.run = 1'b1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rf_req", {15'd0, bus.mem_req}, 16'h0001);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h1234;
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outs("rf_async");
    chk("rf_async_ir", bus.ir, 16'h0000);
    @(negedge clk);
    chk("rf_held_ir",  bus.ir,              16'h0000);
    chk("rf_held_req", {15'd0, bus.mem_req}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    chk("rf_restart_req", {15'd0, bus.mem_req}, 16'h0001);
    chk("rf_restart_ir",  bus.ir,               16'h0000);
    @(negedge clk);
    chk("rf_exec_ir",  bus.ir,              16'h1234);
    chk("rf_exec_inc", {15'd0, bus.inc},     16'h0001);
    chk("rf_exec_cnt", bus.icount,           16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
